// File: rtl/common_pkg.sv
// Shared types and sizing constants for the front-end pipeline.
package common;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int FETCHQ_DEPTH = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: captures {pc, instr} pairs from fetch and
// presents them in program order to decode; a flush drops every held entry.
module fetch_queue
    import common::*;
#(
    parameter  int DEPTH = FETCHQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [63:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    output logic [63:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Handshake flags come only from registered count, so no in_* or
    // out_ready input reaches them combinationally.
    assign w_in_ready  = (r_count != FULL_COUNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready & ~flush;
    assign w_pop       = w_out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; resetting the pointers is enough to drop it.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_pc    = r_mem[r_rd_ptr].pc;
    assign out_instr = r_mem[r_rd_ptr].instr;
    assign count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, single pass, fill/full, streaming wrap,
// flush priority and head hold, each step checked against hand-computed values.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int total;
    int bad;

    fetch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        $display("reset released, count=%0d", count);

        // Single pass
        in_valid = 1'b1; in_pc = 64'h8000_0000; in_instr = 32'h0000_0013;
        tick();
        in_valid = 1'b0;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_pc", out_pc, 64'h8000_0000);
        chk("single_out_instr", 64'(out_instr), 64'h13);
        chk("single_count", 64'(count), 64'd1);
        $display("single push pc=%h instr=%h", out_pc, out_instr);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_out_valid", 64'(out_valid), 64'd0);
        chk("single_pop_count", 64'(count), 64'd0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 64'h8000_0000 + 64'(4 * i); in_instr = 32'h100 + 32'(i);
            tick();
            $display("fill push %0d pc=%h count=%0d", i, in_pc, count);
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_pc = 64'hDEAD_BEEF; in_instr = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        chk("full_ignore_count", 64'(count), 64'd4);
        chk("full_ignore_head", out_pc, 64'h8000_0000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
            chk("drain_instr", 64'(out_instr), 64'h100 + 64'(i));
            $display("drain %0d pc=%h", i, out_pc);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_in_ready", 64'(in_ready), 64'd1);

        // Streaming across the pointer wrap
        in_valid = 1'b1; in_pc = 64'h1000; in_instr = 32'h2000;
        tick();
        chk("stream_start_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc = 64'h1000 + 64'(4 * (k + 1)); in_instr = 32'h2000 + 32'(k + 1);
            chk("stream_head_pc", out_pc, 64'h1000 + 64'(4 * k));
            chk("stream_head_instr", 64'(out_instr), 64'h2000 + 64'(k));
            tick();
            chk("stream_count", 64'(count), 64'd1);
            $display("stream %0d head pc=%h count=%0d", k, out_pc, count);
        end
        in_valid = 1'b0;
        chk("stream_last_pc", out_pc, 64'h1028);
        tick();
        out_ready = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);

        // Flush wins over simultaneous push and pop
        in_valid = 1'b1; in_pc = 64'h2000; in_instr = 32'hA;
        tick();
        in_pc = 64'h2004; in_instr = 32'hB;
        tick();
        chk("flush_pre_count", 64'(count), 64'd2);
        in_pc = 64'h3000; in_instr = 32'hC; out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        in_pc = 64'h4000; in_instr = 32'hD;
        tick();
        in_valid = 1'b0;
        chk("post_flush_count", 64'(count), 64'd1);
        chk("post_flush_head_pc", out_pc, 64'h4000);
        chk("post_flush_head_instr", 64'(out_instr), 64'hD);
        $display("flush done, head pc=%h", out_pc);

        // Head held stable under back-pressure
        in_valid = 1'b1; in_pc = 64'h4004; in_instr = 32'hE;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_out_pc", out_pc, 64'h4000);
            chk("hold_out_instr", 64'(out_instr), 64'hD);
            $display("hold %0d pc=%h instr=%h", i, out_pc, out_instr);
        end

        // Asynchronous reset with three entries held
        in_valid = 1'b1; in_pc = 64'h4008; in_instr = 32'hF;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_count", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_out_pc", out_pc, 64'd0);
        $display("async reset applied, count=%0d", count);
        #3;
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
